// File: rtl/hilo_md_ctrl_if.sv
// HI/LO sequencer bundle: EX-side request, multiplier/divider links, HI/LO.
// No latency of its own; pure wiring between the sequencer and its neighbours.
// Backpressure is carried by stallreq (sequencer -> EX) and div_ready (divider -> sequencer).
interface hilo_md_ctrl_if;
  // EX-side request
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall_ex;
  logic        flush;
  logic        stallreq;
  // multiplier link
  logic        mul_signed;
  logic [31:0] mul_ina;
  logic [31:0] mul_inb;
  logic [63:0] mul_result;
  // divider link
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  // architectural state
  logic [31:0] hi;
  logic [31:0] lo;

  // Sequencer view
  modport slave (
    input  op_valid, op, src_a, src_b, stall_ex, flush,
    input  mul_result, div_result, div_ready,
    output stallreq, mul_signed, mul_ina, mul_inb,
    output div_start, div_signed, div_opdata1, div_opdata2, div_annul,
    output hi, lo
  );

  // Environment view (EX stage, multiplier, divider)
  modport master (
    output op_valid, op, src_a, src_b, stall_ex, flush,
    output mul_result, div_result, div_ready,
    input  stallreq, mul_signed, mul_ina, mul_inb,
    input  div_start, div_signed, div_opdata1, div_opdata2, div_annul,
    input  hi, lo
  );
endinterface

// File: rtl/hilo_md_ctrl.sv
// Multiply/divide sequencer owning the HI/LO pair; issues MULT/DIV to external units, handles MTHI/MTLO.
// Latency: mult MUL_LAT+1 stall cycles, div until div_ready, div-by-zero 1 stall cycle, MTHI/MTLO none.
// Backpressure: stallreq holds EX while busy; DONE waits out stall_ex so a held instruction is not re-issued.
module hilo_md_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           resetn,
  hilo_md_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  state_t      state_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic        sgn_q;
  logic [3:0]  cnt_q;

  logic is_md_op;
  logic issue_ok;

  // Multi-cycle ops are the ones that may need EX held
  assign is_md_op = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
  // A squashed EX instruction must not start anything or touch HI/LO
  assign issue_ok = bus.op_valid & ~bus.flush;

  // Sequencer FSM, operand latches and HI/LO writes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue_ok) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                opa_q   <= bus.src_a;
                opb_q   <= bus.src_b;
                sgn_q   <= (bus.op == OP_MULT);
                cnt_q   <= 4'(MUL_LAT);
                state_q <= MUL_WAIT;
              end
              OP_DIV, OP_DIVU: begin
                // Zero divisor: skip the divider entirely, HI/LO keep their values
                if (bus.src_b != 32'd0) begin
                  opa_q   <= bus.src_a;
                  opb_q   <= bus.src_b;
                  sgn_q   <= (bus.op == OP_DIV);
                  state_q <= DIV_RUN;
                end else begin
                  state_q <= DONE;
                end
              end
              OP_MTHI: hi_q <= bus.src_a;
              OP_MTLO: lo_q <= bus.src_a;
              default: ;
            endcase
          end
        end
        MUL_WAIT: begin
          // Flush wins over a coincident product capture
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              hi_q    <= bus.mul_result[63:32];
              lo_q    <= bus.mul_result[31:0];
              state_q <= DONE;
            end
          end
        end
        DIV_RUN: begin
          // Flush wins over a coincident divider result
          if (bus.flush) begin
            state_q <= IDLE;
          end else if (bus.div_ready) begin
            hi_q    <= bus.div_result[63:32];
            lo_q    <= bus.div_result[31:0];
            state_q <= DONE;
          end
        end
        DONE: begin
          // The finished instruction is still in EX while stall_ex holds it
          if (bus.flush || !bus.stall_ex) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // EX stall request; forced low during reset so every output reads 0
  assign bus.stallreq = resetn & ~bus.flush &
                        (((state_q == IDLE) & bus.op_valid & is_md_op) |
                         (state_q == MUL_WAIT) | (state_q == DIV_RUN));

  // Divider control: start held until the result cycle, annul only on a flush while running
  assign bus.div_start = (state_q == DIV_RUN) & ~bus.div_ready & ~bus.flush;
  assign bus.div_annul = (state_q == DIV_RUN) & bus.flush;

  // Unit operands come from the latches only, never straight from EX
  assign bus.mul_signed  = sgn_q;
  assign bus.mul_ina     = opa_q;
  assign bus.mul_inb     = opb_q;
  assign bus.div_signed  = sgn_q;
  assign bus.div_opdata1 = opa_q;
  assign bus.div_opdata2 = opb_q;

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: doc/hilo_md_ctrl.md
Name: hilo_md_ctrl

Overview:
- Multi-cycle multiply/divide sequencer with the architectural HI/LO register pair; sits beside the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX.
- Drives the pipelined multiplier and the iterative divider, and raises the EX stall request until each result is captured.
- Writes HI/LO and cancels in-flight operations on flush.

Parameters:
- MUL_LAT, 2, cycles from the multiplier operands first being presented to a valid mul_result; legal range 1..15.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- op_valid  in  1  EX holds a HI/LO-class instruction this cycle
- op  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 111 reserved
- src_a  in  32  rs value
- src_b  in  32  rt value
- stall_ex  in  1  EX held by a stall source other than this block
- flush  in  1  squash the EX instruction
- stallreq  out  1  request EX/earlier-stage stall
- mul_signed  out  1  multiplier signed select
- mul_ina  out  32  multiplier operand a
- mul_inb  out  32  multiplier operand b
- mul_result  in  64  multiplier product
- div_start  out  1  divider start/hold
- div_signed  out  1  divider signed select
- div_opdata1  out  32  dividend
- div_opdata2  out  32  divisor
- div_annul  out  1  abort divider
- div_result  in  64  {remainder, quotient}
- div_ready  in  1  divider result valid, one-cycle pulse
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; hi, lo, operand latches, signed flag and counter all clear to 0.
  - All outputs 0.
- States: IDLE, MUL_WAIT, DIV_RUN, DONE.
- Datapath outputs:
  - mul_ina/mul_inb/div_opdata1/div_opdata2/mul_signed/div_signed are driven only from the latched operands and flag.
  - Signed = op 001 or 011.
- stallreq = ~flush & ((IDLE & op_valid & op∈{001..100}) | MUL_WAIT | DIV_RUN). It is 0 in DONE.
- IDLE transitions:
  - mult/multu: latch src_a/src_b/signed; cnt←MUL_LAT; →MUL_WAIT.
  - div/divu with src_b≠0: latch; →DIV_RUN.
  - div/divu with src_b=0: no divider activity; →DONE; HI/LO unchanged.
  - mthi: hi←src_a at the edge, no stall, stay IDLE.
  - mtlo: lo←src_a at the edge, no stall, stay IDLE.
  - op 000/111 or op_valid=0: no action.
- MUL_WAIT:
  - Decrement cnt each cycle.
  - When cnt==1: hi←mul_result[63:32], lo←mul_result[31:0]; →DONE.
  - MUL_LAT=2 gives 3 stall cycles; DONE in the 4th cycle.
- DIV_RUN:
  - div_start=1 until div_ready.
  - On the div_ready cycle: div_start=0; hi←div_result[63:32], lo←div_result[31:0]; →DONE.
- DONE:
  - Stay in DONE while stall_ex=1. This prevents re-issue of the held instruction.
  - Otherwise →IDLE.
- Flush:
  - In MUL_WAIT or DIV_RUN: →IDLE next edge, no HI/LO write.
  - If in DIV_RUN, div_annul=1 that cycle (one cycle only) and div_start=0.
  - Flush takes priority over a coincident div_ready or cnt==1 capture.
  - Flush in IDLE: suppresses the issue and any mthi/mtlo write.
  - Flush in DONE: →IDLE; HI/LO stay written.
- hi/lo change only at the edges listed above. The new values are visible the cycle after the write.
- Reset asserted mid-operation: immediate return to IDLE; no pending write survives.

Test Plan:
1. mult, src_a=FFFFFFFD, src_b=00000005, MUL_LAT=2 -> stallreq high 3 cycles; then hi=FFFFFFFF, lo=FFFFFFF1; DONE one cycle; IDLE.
2. multu, src_a=FFFFFFFF, src_b=00000002 -> hi=00000001, lo=FFFFFFFE; mul_signed=0 throughout.
3. div, src_a=FFFFFFF9, src_b=00000002; divider model raises ready after 33 cycles -> div_start high 33 cycles; stallreq drops on the ready cycle; hi=FFFFFFFF, lo=FFFFFFFD.
4. divu with src_b=0 -> no div_start; stallreq high 1 cycle; hi/lo unchanged; then mthi 12345678 with stall_ex=1 for 3 cycles -> hi=12345678 and no stall asserted.
5. div issued; flush at DIV_RUN cycle 10 -> div_annul one-cycle pulse; state IDLE; hi/lo unchanged; divider ready pulse later ignored.
6. mult in flight; resetn dropped asynchronously mid-MUL_WAIT -> hi=lo=0, stallreq=0 immediately; then mtlo 0000ABCD with simultaneous flush -> lo stays 0.
